alu_cmd_issuer: RTL and testbench

Command-side driver for the registered N-bit ALU stage. It accepts one ALU command at a time from an upstream valid/ready channel and drives operands and operation onto the ALU inputs, holding them stable. It waits out the ALU's registered result latency, captures the result, and returns it with the command's tag on a downstream valid/ready response channel. It sits between a command source (sequencer, bus slave or testbench agent) and the ALU's `operand1/operand2/operation/result` ports, and shares the ALU's clock and reset.

---
 rtl/alu_cmd_issuer.sv | 112 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a registered ALU, waits out its latency,
// and returns the captured result with the command tag on a response channel.
module alu_cmd_issuer #(
    parameter int N    = 4,
    parameter int LAT  = 1,
    parameter int TAGW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [N-1:0]    cmd_op1,
    input  logic [N-1:0]    cmd_op2,
    input  logic [1:0]      cmd_operation,
    input  logic [TAGW-1:0] cmd_tag,
    output logic [N-1:0]    alu_operand1,
    output logic [N-1:0]    alu_operand2,
    output logic [1:0]      alu_operation,
    input  logic [N-1:0]    alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            busy,
    output logic [7:0]      done_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int CW = $clog2(LAT + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [TAGW-1:0] tag_q;
    logic            accept;
    logic            capture;
    logic            handshake;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // counter hits zero on this edge: the ALU result is now valid
                if (cnt == CNT_LAST) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_operation <= '0;
            tag_q         <= '0;
            cnt           <= '0;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            done_count    <= '0;
        end else begin
            if (accept) begin
                alu_operand1  <= cmd_op1;
                alu_operand2  <= cmd_op2;
                alu_operation <= cmd_operation;
                tag_q         <= cmd_tag;
                cnt           <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_LAST;
            end
            if (capture) begin
                rsp_data <= alu_result;
                rsp_tag  <= tag_q;
            end
            if (handshake) done_count <= done_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with LAT=1 and LAT=3 instances,
// registered ALU models and an in-order response scoreboard.
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic       a_valid, a_ready, a_rsp_valid, a_rsp_ready, a_busy;
    logic [3:0] a_op1, a_op2, a_alu1, a_alu2, a_res, a_rsp_data;
    logic [1:0] a_op, a_tag, a_alu_op, a_rsp_tag;
    logic [7:0] a_done;

    logic       b_valid, b_ready, b_rsp_valid, b_rsp_ready, b_busy;
    logic [3:0] b_op1, b_op2, b_alu1, b_alu2, b_res, b_rsp_data;
    logic [1:0] b_op, b_tag, b_alu_op, b_rsp_tag;
    logic [7:0] b_done;
    logic [3:0] b_s1, b_s2;

    alu_cmd_issuer #(.N(4), .LAT(1), .TAGW(2)) dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op1(a_op1), .cmd_op2(a_op2),
        .cmd_operation(a_op), .cmd_tag(a_tag),
        .alu_operand1(a_alu1), .alu_operand2(a_alu2),
        .alu_operation(a_alu_op), .alu_result(a_res),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag),
        .busy(a_busy), .done_count(a_done)
    );

    alu_cmd_issuer #(.N(4), .LAT(3), .TAGW(2)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op1(b_op1), .cmd_op2(b_op2),
        .cmd_operation(b_op), .cmd_tag(b_tag),
        .alu_operand1(b_alu1), .alu_operand2(b_alu2),
        .alu_operation(b_alu_op), .alu_result(b_res),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag),
        .busy(b_busy), .done_count(b_done)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] x, input logic [3:0] y,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x + y;
            default: return x ^ y;
        endcase
    endfunction

    // ALU models: one register stage for LAT=1, three for LAT=3
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_res <= '0;
            b_s1  <= '0;
            b_s2  <= '0;
            b_res <= '0;
        end else begin
            a_res <= alu_f(a_alu1, a_alu2, a_alu_op);
            b_s1  <= alu_f(b_alu1, b_alu2, b_alu_op);
            b_s2  <= b_s1;
            b_res <= b_s2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [5:0] q_a[$];
    logic [5:0] q_b[$];
    logic [5:0] e;

    // Scoreboard: push on an accept, pop on a response handshake
    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_valid && a_ready) q_a.push_back({a_tag, alu_f(a_op1, a_op2, a_op)});
            if (b_valid && b_ready) q_b.push_back({b_tag, alu_f(b_op1, b_op2, b_op)});
            if (a_rsp_valid && a_rsp_ready) begin
                if (q_a.size() == 0) chk("a_rsp_unexpected", 0, 1);
                else begin
                    e = q_a.pop_front();
                    chk("a_sb_tag", a_rsp_tag, e[5:4]);
                    chk("a_sb_data", a_rsp_data, e[3:0]);
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (q_b.size() == 0) chk("b_rsp_unexpected", 0, 1);
                else begin
                    e = q_b.pop_front();
                    chk("b_sb_tag", b_rsp_tag, e[5:4]);
                    chk("b_sb_data", b_rsp_data, e[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] o1, input logic [3:0] o2,
                          input logic [1:0] op, input logic [1:0] tg);
        int n = 0;
        a_op1 = o1; a_op2 = o2; a_op = op; a_tag = tg;
        a_valid = 1'b1;
        while (!a_ready && n < 20) begin tick(); n++; end
        chk("a_accept_timeout", n < 20, 1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_rsp_a();
        int n = 0;
        while (!a_rsp_valid && n < 20) begin tick(); n++; end
        chk("a_rsp_timeout", n < 20, 1);
    endtask

    initial begin
        int n;
        int stamp;
        int prev;
        logic seen;
        a_valid = 0; a_op1 = 0; a_op2 = 0; a_op = 0; a_tag = 0; a_rsp_ready = 0;
        b_valid = 0; b_op1 = 0; b_op2 = 0; b_op = 0; b_tag = 0; b_rsp_ready = 0;

        // reset values, asserted with no clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_data", a_rsp_data, 0);
        chk("rst_rsp_tag", a_rsp_tag, 0);
        chk("rst_alu", {a_alu1, a_alu2, a_alu_op}, 0);
        chk("rst_done", a_done, 0);
        tick(); tick();
        reset = 1'b0;

        // single command, LAT=1
        a_rsp_ready = 1'b1;
        a_op1 = 4'h3; a_op2 = 4'h5; a_op = 2'b10; a_tag = 2'd1; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("e0_operand1", a_alu1, 4'h3);
        chk("e0_operand2", a_alu2, 4'h5);
        chk("e0_operation", a_alu_op, 2'b10);
        chk("e0_cmd_ready", a_ready, 0);
        chk("e0_busy", a_busy, 1);
        tick();
        chk("e1_rsp_valid", a_rsp_valid, 0);
        tick();
        chk("e2_rsp_valid", a_rsp_valid, 1);
        chk("e2_rsp_data", a_rsp_data, 4'h8);
        chk("e2_rsp_tag", a_rsp_tag, 2'd1);
        tick();
        chk("e3_rsp_valid", a_rsp_valid, 0);
        chk("e3_done", a_done, 1);
        chk("e3_cmd_ready", a_ready, 1);
        chk("e3_hold_operand1", a_alu1, 4'h3);

        // backpressure
        a_rsp_ready = 1'b0;
        send_a(4'h7, 4'h1, 2'b00, 2'd2);
        wait_rsp_a();
        for (int i = 0; i < 5; i++) begin
            a_valid = (i == 2);
            a_tag = 2'd3;
            tick();
            chk("bp_rsp_valid", a_rsp_valid, 1);
            chk("bp_rsp_data", a_rsp_data, 4'h1);
            chk("bp_rsp_tag", a_rsp_tag, 2'd2);
            chk("bp_cmd_ready", a_ready, 0);
        end
        a_valid = 1'b0;
        a_rsp_ready = 1'b1;
        tick();
        chk("bp_done", a_done, 2);
        chk("bp_rsp_cleared", a_rsp_valid, 0);
        chk("bp_no_accept", a_busy, 0);

        // reset mid-WAIT drops the in-flight command
        send_a(4'h9, 4'h4, 2'b10, 2'd3);
        tick();
        reset = 1'b1;
        #1;
        chk("mw_busy", a_busy, 0);
        chk("mw_cmd_ready", a_ready, 1);
        chk("mw_done", a_done, 0);
        chk("mw_operand1", a_alu1, 0);
        tick(); tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= a_rsp_valid;
            tick();
        end
        chk("mw_no_rsp", seen, 0);
        send_a(4'h6, 4'h3, 2'b11, 2'd0);
        wait_rsp_a();
        chk("mw_next_data", a_rsp_data, 4'h5);
        tick();
        chk("mw_next_done", a_done, 1);

        // 257 back-to-back commands, counter wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_rsp_ready = 1'b1;
        a_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 257; i++) begin
            a_op1 = 4'($urandom);
            a_op2 = 4'($urandom);
            a_op = 2'($urandom);
            a_tag = 2'(i);
            n = 0;
            while (!a_ready && n < 20) begin tick(); n++; end
            tick();
            stamp = cyc;
            if (i > 0) chk("b2b_spacing", stamp - prev, 4);
            prev = stamp;
        end
        a_valid = 1'b0;
        wait_rsp_a();
        tick();
        chk("b2b_done_wrap", a_done, 1);
        chk("b2b_sb_empty", q_a.size(), 0);
        chk("b2b_idle", a_rsp_valid, 0);

        // LAT=3: the sample must see the new result, not the stale one
        b_rsp_ready = 1'b1;
        b_op1 = 4'h1; b_op2 = 4'h1; b_op = 2'b10; b_tag = 2'd1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 20) begin tick(); n++; end
        chk("l3_first_timeout", n < 20, 1);
        tick();
        b_op1 = 4'h5; b_op2 = 4'h6; b_op = 2'b10; b_tag = 2'd2; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick(); tick(); tick();
        chk("l3_e3_rsp_valid", b_rsp_valid, 0);
        tick();
        chk("l3_e4_rsp_valid", b_rsp_valid, 1);
        chk("l3_e4_rsp_data", b_rsp_data, 4'hb);
        chk("l3_e4_rsp_tag", b_rsp_tag, 2'd2);
        tick();
        chk("l3_done", b_done, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
